// File: rtl/sub_stage_pkg.sv
// Shared definitions for the subtractor result stage: occupancy states and
// condition-flag layout.
package sub_stage_pkg;

  localparam int FLAG_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

endpackage : sub_stage_pkg

// File: rtl/sub_flag_gen.sv
// Combinational {V, N, Z, C} flag derivation from a subtract result and the
// operand sign bits.
module sub_flag_gen
  import sub_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  inDiff,
  input  logic              inBorrow,
  input  logic              inAMsb,
  input  logic              inBMsb,
  output logic [FLAG_W-1:0] flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_C] = inBorrow;
    flags[FLAG_Z] = (inDiff == '0);
    flags[FLAG_N] = inDiff[WIDTH-1];
    // Signed overflow: operands differ in sign and result sign disagrees with minuend.
    flags[FLAG_V] = (inAMsb != inBMsb) && (inDiff[WIDTH-1] != inAMsb);
  end

endmodule : sub_flag_gen

// File: rtl/sub_result_stage.sv
// Two-entry registered result stage (head + skid) between the subtractor and
// the writeback/flags consumer.
module sub_result_stage
  import sub_stage_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WIDTH-1:0]  inDiff,
  input  logic              inBorrow,
  input  logic              inAMsb,
  input  logic              inBMsb,
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [WIDTH-1:0]  outDiff,
  output logic [FLAG_W-1:0] outFlags
);

  generate
    if (DEPTH != 2) begin : gDepthCheck
      $error("sub_result_stage supports DEPTH == 2 only");
    end
  endgenerate

  logic [1:0]        stateReg;
  logic [WIDTH-1:0]  headDiffReg;
  logic [FLAG_W-1:0] headFlagsReg;
  logic [WIDTH-1:0]  skidDiffReg;
  logic [FLAG_W-1:0] skidFlagsReg;
  logic [FLAG_W-1:0] newFlags;
  logic              push;
  logic              pop;

  sub_flag_gen #(
    .WIDTH (WIDTH)
  ) uFlagGen (
    .inDiff   (inDiff),
    .inBorrow (inBorrow),
    .inAMsb   (inAMsb),
    .inBMsb   (inBMsb),
    .flags    (newFlags)
  );

  // Handshake decodes depend on registered state only.
  assign inReady  = (stateReg != TWO);
  assign outValid = (stateReg == ONE) || (stateReg == TWO);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;
  assign outDiff  = headDiffReg;
  assign outFlags = headFlagsReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= EMPTY;
      headDiffReg  <= '0;
      headFlagsReg <= '0;
      skidDiffReg  <= '0;
      skidFlagsReg <= '0;
    end else if (flush) begin
      stateReg     <= EMPTY;
      headDiffReg  <= '0;
      headFlagsReg <= '0;
    end else begin
      case (stateReg)
        EMPTY: begin
          if (push) begin
            headDiffReg  <= inDiff;
            headFlagsReg <= newFlags;
            stateReg     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            headDiffReg  <= inDiff;
            headFlagsReg <= newFlags;
          end else if (push) begin
            skidDiffReg  <= inDiff;
            skidFlagsReg <= newFlags;
            stateReg     <= TWO;
          end else if (pop) begin
            // Zero the head so nothing stale sits on the outputs while empty.
            headDiffReg  <= '0;
            headFlagsReg <= '0;
            stateReg     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            headDiffReg  <= skidDiffReg;
            headFlagsReg <= skidFlagsReg;
            stateReg     <= ONE;
          end
        end
        default: begin
          headDiffReg  <= '0;
          headFlagsReg <= '0;
          stateReg     <= EMPTY;
        end
      endcase
    end
  end

endmodule : sub_result_stage

// File: tb/tb_sub_result_stage.sv
// Directed bench for sub_result_stage: capture, flags, backpressure,
// streaming, flush and asynchronous reset.
module tb_sub_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid;
  logic       inReady;
  logic [7:0] inDiff;
  logic       inBorrow;
  logic       inAMsb;
  logic       inBMsb;
  logic       flush;
  logic       outValid;
  logic       outReady;
  logic [7:0] outDiff;
  logic [3:0] outFlags;

  int assertCount = 0;
  int failCount   = 0;

  sub_result_stage #(.WIDTH(8), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inDiff   (inDiff),
    .inBorrow (inBorrow),
    .inAMsb   (inAMsb),
    .inBMsb   (inBMsb),
    .flush    (flush),
    .outValid (outValid),
    .outReady (outReady),
    .outDiff  (outDiff),
    .outFlags (outFlags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp)
      $display("check %-16s observed %h expected %h ok", tag, obs, exp);
    else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic b,
                       input logic am, input logic bm);
    inValid  = v;
    inDiff   = d;
    inBorrow = b;
    inAMsb   = am;
    inBMsb   = bm;
  endtask

  task automatic checkEmpty(input string tag);
    check({tag, ".valid"}, {15'd0, outValid}, 16'd0);
    check({tag, ".diff"},  {8'd0, outDiff},   16'd0);
    check({tag, ".flags"}, {12'd0, outFlags}, 16'd0);
    check({tag, ".ready"}, {15'd0, inReady},  16'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    outReady = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checkEmpty("reset");
    #12 rst_n = 1'b1;
    tick();

    // Basic capture 0x05-0x03
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    tick();
    check("basic.valid", {15'd0, outValid}, 16'd1);
    check("basic.diff",  {8'd0, outDiff},   16'h02);
    check("basic.flags", {12'd0, outFlags}, 16'b0000);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkEmpty("basic.after");

    // 0x03-0x05 then 0x44-0x44
    drive(1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);
    tick();
    check("neg.diff",  {8'd0, outDiff},   16'hFE);
    check("neg.flags", {12'd0, outFlags}, 16'b0101);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("zero.valid", {15'd0, outValid}, 16'd1);
    check("zero.diff",  {8'd0, outDiff},   16'h00);
    check("zero.flags", {12'd0, outFlags}, 16'b0010);

    // Overflow cases 0x80-0x01 and 0x7F-0xFF
    drive(1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
    tick();
    check("ovf1.diff",  {8'd0, outDiff},   16'h7F);
    check("ovf1.flags", {12'd0, outFlags}, 16'b1000);
    drive(1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
    tick();
    check("ovf2.diff",  {8'd0, outDiff},   16'h80);
    check("ovf2.flags", {12'd0, outFlags}, 16'b1101);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkEmpty("ovf.after");

    // Backpressure: two entries fill the stage, third is held off
    outReady = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp.first",  {8'd0, outDiff},  16'h11);
    check("bp.ready1", {15'd0, inReady}, 16'd1);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp.ready2", {15'd0, inReady}, 16'd0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.hold.diff",  {8'd0, outDiff},   16'h11);
      check("bp.hold.flags", {12'd0, outFlags}, 16'b0000);
      check("bp.hold.ready", {15'd0, inReady},  16'd0);
    end
    outReady = 1'b1;
    tick();
    check("bp.drain1", {8'd0, outDiff},  16'h22);
    check("bp.ready3", {15'd0, inReady}, 16'd1);
    tick();
    check("bp.drain2", {8'd0, outDiff},   16'h33);
    check("bp.valid2", {15'd0, outValid}, 16'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkEmpty("bp.after");

    // Streaming through ONE at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
      check("stream.diff",  {8'd0, outDiff},   16'(i));
      check("stream.valid", {15'd0, outValid}, 16'd1);
      check("stream.ready", {15'd0, inReady},  16'd1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkEmpty("stream.after");

    // Flush from TWO with a concurrent push
    outReady = 1'b0;
    drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    tick();
    check("flush.full", {15'd0, inReady}, 16'd0);
    flush = 1'b1;
    drive(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkEmpty("flush");
    outReady = 1'b1;
    tick();
    checkEmpty("flush.dropped");

    // Asynchronous reset mid-cycle from TWO
    outReady = 1'b0;
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("arst.full", {15'd0, inReady}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    checkEmpty("arst");
    #2 rst_n = 1'b1;
    outReady = 1'b1;
    tick();
    checkEmpty("arst.after");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_sub_result_stage
